control_sequencer: RTL and testbench

Hardwired control unit that drives the DataPath control inputs. It steps through fetch (T0–T2) and execute (T3–T6) time steps and decodes the IR fields into one-hot register-enable vectors and the ALU opcode. It sits directly upstream of DataPath and replaces the hand-sequenced stimulus now used to exercise it. It also handles a memory-ready handshake, a fetch timeout, halt, and illegal-opcode detection.

---
 rtl/control_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute control unit driving the DataPath control inputs
module control_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_WIDTH   = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  alu_op,
    output logic [3:0]  state_out,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal,
    output logic        bus_error
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_W    = 4'd3,
        S_T2   = 4'd4,
        S_T3   = 4'd5,
        S_T4   = 4'd6,
        S_T5   = 4'd7,
        S_T6   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    localparam logic [TMR_WIDTH-1:0] TIMEOUT_CNT = TMR_WIDTH'(MEM_TIMEOUT);

    state_t               state;
    state_t               state_next;
    logic [TMR_WIDTH-1:0] wait_cnt;
    logic                 cnt_load;
    logic                 cnt_inc;
    logic                 timeout_hit;

    logic [4:0]  opcode;
    logic [15:0] ra_oh;
    logic [15:0] rb_oh;
    logic [15:0] rc_oh;
    logic        is_rtype;
    logic        is_unary;
    logic        is_muldiv;
    logic        is_nop;
    logic        is_halt;
    logic        unused_ir;

    assign opcode    = ir[31:27];
    assign ra_oh     = 16'd1 << ir[26:23];
    assign rb_oh     = 16'd1 << ir[22:19];
    assign rc_oh     = 16'd1 << ir[18:15];
    assign unused_ir = ^ir[14:0];
    assign state_out = state;

    always_comb begin
        is_rtype  = 1'b0;
        is_unary  = 1'b0;
        is_muldiv = 1'b0;
        is_nop    = 1'b0;
        is_halt   = 1'b0;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: is_rtype  = 1'b1;
            5'b10001, 5'b10010:                     is_unary  = 1'b1;
            5'b01111, 5'b10000:                     is_muldiv = 1'b1;
            5'b11010:                               is_nop    = 1'b1;
            5'b11011:                               is_halt   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wait_cnt  <= '0;
            bus_error <= 1'b0;
        end else begin
            if (cnt_load) begin
                wait_cnt <= TMR_WIDTH'(1);
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + TMR_WIDTH'(1);
            end
            if (timeout_hit) begin
                bus_error <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        timeout_hit = 1'b0;
        PCout       = 1'b0;
        PCin        = 1'b0;
        IncPC       = 1'b0;
        MARin       = 1'b0;
        Read        = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        Zhighout    = 1'b0;
        Zlowout     = 1'b0;
        HIin        = 1'b0;
        LOin        = 1'b0;
        Rin         = '0;
        Rout        = '0;
        alu_op      = '0;
        instr_done  = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_next = S_T0;
            end
            S_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zin        = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) begin
                    state_next = S_T2;
                end else begin
                    state_next = S_W;
                    cnt_load   = 1'b1;
                end
            end
            S_W: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                // A late mem_ready still completes the fetch even on the timeout cycle
                if (mem_ready) begin
                    state_next = S_T2;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    state_next  = S_HALT;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (is_rtype) begin
                    Rout       = rb_oh;
                    Yin        = 1'b1;
                    state_next = S_T4;
                end else if (is_unary) begin
                    Rout       = rb_oh;
                    alu_op     = opcode;
                    Zin        = 1'b1;
                    state_next = S_T4;
                end else if (is_muldiv) begin
                    Rout       = ra_oh;
                    Yin        = 1'b1;
                    state_next = S_T4;
                end else if (is_nop) begin
                    instr_done = 1'b1;
                    state_next = S_IDLE;
                end else if (is_halt) begin
                    instr_done = 1'b1;
                    state_next = S_HALT;
                end else begin
                    illegal    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_T4: begin
                state_next = S_IDLE;
                if (is_rtype) begin
                    Rout       = rc_oh;
                    alu_op     = opcode;
                    Zin        = 1'b1;
                    state_next = S_T5;
                end else if (is_unary) begin
                    Zlowout    = 1'b1;
                    Rin        = ra_oh;
                    instr_done = 1'b1;
                end else if (is_muldiv) begin
                    Rout       = rb_oh;
                    alu_op     = opcode;
                    Zin        = 1'b1;
                    state_next = S_T5;
                end
            end
            S_T5: begin
                state_next = S_IDLE;
                if (is_rtype) begin
                    Zlowout    = 1'b1;
                    Rin        = ra_oh;
                    instr_done = 1'b1;
                end else if (is_muldiv) begin
                    Zlowout    = 1'b1;
                    LOin       = 1'b1;
                    state_next = S_T6;
                end
            end
            S_T6: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                instr_done = 1'b1;
                state_next = S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;
    logic [3:0]  state_out;
    logic        instr_done, halted, illegal, bus_error;

    int checks;
    int failures;

    control_sequencer #(.MEM_TIMEOUT(15), .TMR_WIDTH(4)) dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout), .alu_op(alu_op),
        .state_out(state_out), .instr_done(instr_done), .halted(halted),
        .illegal(illegal), .bus_error(bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [13:0] C_PCOUT = 14'h2000, C_PCIN  = 14'h1000, C_INCPC = 14'h0800;
    localparam logic [13:0] C_MARIN = 14'h0400, C_READ  = 14'h0200, C_MDRIN = 14'h0100;
    localparam logic [13:0] C_MDROUT = 14'h0080, C_IRIN = 14'h0040, C_YIN   = 14'h0020;
    localparam logic [13:0] C_ZIN   = 14'h0010, C_ZHI   = 14'h0008, C_ZLO   = 14'h0004;
    localparam logic [13:0] C_HIIN  = 14'h0002, C_LOIN  = 14'h0001;
    localparam logic [3:0]  F_DONE = 4'h8, F_HALT = 4'h4, F_ILL = 4'h2, F_BUS = 4'h1;

    logic [58:0] obs;
    assign obs = {state_out,
                  PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                  Yin, Zin, Zhighout, Zlowout, HIin, LOin,
                  Rin, Rout, alu_op, instr_done, halted, illegal, bus_error};

    function automatic logic [58:0] ev(input logic [3:0] st, input logic [13:0] c,
                                       input logic [15:0] rin, input logic [15:0] rout,
                                       input logic [4:0] alu, input logic [3:0] f);
        return {st, c, rin, rout, alu, f};
    endfunction

    function automatic logic [58:0] e_idle();
        return ev(4'd0, 14'h0, 16'h0, 16'h0, 5'd0, 4'h0);
    endfunction
    function automatic logic [58:0] e_t0();
        return ev(4'd1, C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 16'h0, 16'h0, 5'd0, 4'h0);
    endfunction
    function automatic logic [58:0] e_t1();
        return ev(4'd2, C_ZLO | C_PCIN | C_READ | C_MDRIN, 16'h0, 16'h0, 5'd0, 4'h0);
    endfunction
    function automatic logic [58:0] e_w();
        return ev(4'd3, C_READ | C_MDRIN, 16'h0, 16'h0, 5'd0, 4'h0);
    endfunction
    function automatic logic [58:0] e_t2();
        return ev(4'd4, C_MDROUT | C_IRIN, 16'h0, 16'h0, 5'd0, 4'h0);
    endfunction

    task automatic test_reset();
        clear = 1'b1;
        #3;
        if (obs !== e_idle()) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", obs, e_idle());
        end
        checks++;
        @(negedge clock);
        clear = 1'b0;
    endtask

    // and R4,R3,R7
    task automatic test_rtype();
        logic [58:0] e [7];
        e = '{e_t0(), e_t1(), e_t2(),
              ev(4'd5, C_YIN, 16'h0, 16'h0008, 5'd0, 4'h0),
              ev(4'd6, C_ZIN, 16'h0, 16'h0080, 5'b00101, 4'h0),
              ev(4'd7, C_ZLO, 16'h0010, 16'h0, 5'd0, F_DONE),
              e_idle()};
        ir = 32'h2A1B8000; run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL rtype[%0d] got=%h exp=%h", i, obs, e[i]);
            end
            checks++;
            if (i == 5) run = 1'b0;
        end
    endtask

    // mul R5,R6
    task automatic test_mul();
        logic [58:0] e [8];
        e = '{e_t0(), e_t1(), e_t2(),
              ev(4'd5, C_YIN, 16'h0, 16'h0020, 5'd0, 4'h0),
              ev(4'd6, C_ZIN, 16'h0, 16'h0040, 5'b01111, 4'h0),
              ev(4'd7, C_ZLO | C_LOIN, 16'h0, 16'h0, 5'd0, 4'h0),
              ev(4'd8, C_ZHI | C_HIIN, 16'h0, 16'h0, 5'd0, F_DONE),
              e_idle()};
        ir = 32'h7AB00000; run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL mul[%0d] got=%h exp=%h", i, obs, e[i]);
            end
            checks++;
            if (i == 6) run = 1'b0;
        end
    endtask

    // neg R1,R2
    task automatic test_neg();
        logic [58:0] e [6];
        e = '{e_t0(), e_t1(), e_t2(),
              ev(4'd5, C_ZIN, 16'h0, 16'h0004, 5'b10001, 4'h0),
              ev(4'd6, C_ZLO, 16'h0002, 16'h0, 5'd0, F_DONE),
              e_idle()};
        ir = 32'h88900000; run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL neg[%0d] got=%h exp=%h", i, obs, e[i]);
            end
            checks++;
            if (i == 4) run = 1'b0;
        end
    endtask

    // three wait cycles, then a nop
    task automatic test_wait();
        logic [58:0] e [8];
        e = '{e_t0(), e_t1(), e_w(), e_w(), e_w(), e_t2(),
              ev(4'd5, 14'h0, 16'h0, 16'h0, 5'd0, F_DONE),
              e_idle()};
        ir = 32'hD0000000; run = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL wait[%0d] got=%h exp=%h", i, obs, e[i]);
            end
            checks++;
            if (i == 4) mem_ready = 1'b1;
            if (i == 5) run = 1'b0;
        end
    endtask

    task automatic test_timeout();
        logic [58:0] e [19];
        e[0] = e_t0();
        e[1] = e_t1();
        for (int k = 2; k < 17; k++) e[k] = e_w();
        e[17] = ev(4'd9, 14'h0, 16'h0, 16'h0, 5'd0, F_HALT | F_BUS);
        e[18] = e[17];
        ir = 32'h2A1B8000; run = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL timeout[%0d] got=%h exp=%h", i, obs, e[i]);
            end
            checks++;
        end
        run = 1'b0;
        clear = 1'b1;
        #1;
        if (obs !== e_idle()) begin
            failures++;
            $display("FAIL timeout_clear got=%h exp=%h", obs, e_idle());
        end
        checks++;
        @(negedge clock);
        clear = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic test_illegal();
        logic [58:0] e [5];
        e = '{e_t0(), e_t1(), e_t2(),
              ev(4'd5, 14'h0, 16'h0, 16'h0, 5'd0, F_ILL),
              e_idle()};
        ir = 32'hF8000000; run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL illegal[%0d] got=%h exp=%h", i, obs, e[i]);
            end
            checks++;
            if (i == 3) run = 1'b0;
        end
    endtask

    task automatic test_halt();
        logic [58:0] e [7];
        e = '{e_t0(), e_t1(), e_t2(),
              ev(4'd5, 14'h0, 16'h0, 16'h0, 5'd0, F_DONE),
              ev(4'd9, 14'h0, 16'h0, 16'h0, 5'd0, F_HALT),
              ev(4'd9, 14'h0, 16'h0, 16'h0, 5'd0, F_HALT),
              ev(4'd9, 14'h0, 16'h0, 16'h0, 5'd0, F_HALT)};
        ir = 32'hD8000000; run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL halt[%0d] got=%h exp=%h", i, obs, e[i]);
            end
            checks++;
        end
        clear = 1'b1;
        #1;
        if (obs !== e_idle()) begin
            failures++;
            $display("FAIL halt_clear got=%h exp=%h", obs, e_idle());
        end
        checks++;
        @(negedge clock);
        clear = 1'b0;
        run = 1'b0;
    endtask

    task automatic test_clear_mid();
        logic [58:0] e [5];
        e = '{e_t0(), e_t1(), e_t2(),
              ev(4'd5, C_YIN, 16'h0, 16'h0020, 5'd0, 4'h0),
              ev(4'd6, C_ZIN, 16'h0, 16'h0040, 5'b01111, 4'h0)};
        ir = 32'h7AB00000; run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL clear_mid[%0d] got=%h exp=%h", i, obs, e[i]);
            end
            checks++;
        end
        run = 1'b0;
        clear = 1'b1;
        #1;
        if (obs !== e_idle()) begin
            failures++;
            $display("FAIL clear_mid_async got=%h exp=%h", obs, e_idle());
        end
        checks++;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        if (obs !== e_idle()) begin
            failures++;
            $display("FAIL clear_mid_after got=%h exp=%h", obs, e_idle());
        end
        checks++;
    endtask

    task automatic test_run_drop();
        logic [58:0] e [15];
        e = '{e_t0(), e_t1(), e_t2(),
              ev(4'd5, C_YIN, 16'h0, 16'h0008, 5'd0, 4'h0),
              ev(4'd6, C_ZIN, 16'h0, 16'h0080, 5'b00101, 4'h0),
              ev(4'd7, C_ZLO, 16'h0010, 16'h0, 5'd0, F_DONE),
              e_idle(), e_idle(), e_idle(),
              e_t0(), e_t1(), e_t2(),
              ev(4'd5, C_YIN, 16'h0, 16'h0008, 5'd0, 4'h0),
              ev(4'd6, C_ZIN, 16'h0, 16'h0080, 5'b00101, 4'h0),
              ev(4'd7, C_ZLO, 16'h0010, 16'h0, 5'd0, F_DONE)};
        ir = 32'h2A1B8000; run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL run_drop[%0d] got=%h exp=%h", i, obs, e[i]);
            end
            checks++;
            if (i == 4) run = 1'b0;
            if (i == 8) run = 1'b1;
            if (i == 9) run = 1'b0;
        end
        @(negedge clock);
        if (obs !== e_idle()) begin
            failures++;
            $display("FAIL run_drop_end got=%h exp=%h", obs, e_idle());
        end
        checks++;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clear = 1'b0;
        run = 1'b0;
        mem_ready = 1'b0;
        ir = 32'h0;
        test_reset();
        test_rtype();
        test_mul();
        test_neg();
        test_wait();
        test_timeout();
        test_illegal();
        test_halt();
        test_clear_mid();
        test_run_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
